// File: rtl/bram4_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bram4_read_sequencer
// Description : Control-register-driven read sequencer for four single-port
//               BRAMs on a shared address bus. Reads word_count addresses
//               from base_addr, banks 0..3 at each address, absorbs the BRAM
//               read latency and returns words in order on a valid/ready
//               stream, with busy/done/abort status.
// Revision    : 1.0 - initial release
// ============================================================================
module bram4_read_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             control_signal,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     word_count,
    output logic [3:0]              bram_en,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    input  logic [4*DATA_WIDTH-1:0] bram_rd_data,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_bank,
    output logic [31:0]             status_signal
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_REM_W = ADDR_WIDTH + 3;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // FSM / issue state
    logic [1:0]            r_state;
    logic                  r_start_d;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [1:0]            r_next_bank;
    logic [c_REM_W-1:0]    r_remaining;
    logic [3:0]            r_bram_en;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [1:0]            r_bram_bank;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;

    // In-flight tracking pipe: stage j holds a read issued j+1 cycles ago
    logic                  r_pipe_vld  [RD_LATENCY];
    logic [1:0]            r_pipe_bank [RD_LATENCY];

    // Return FIFO, each entry is {bank, data}
    logic [DATA_WIDTH+1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_start_rise;
    logic                  w_abort_req;
    logic                  w_flush;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [7:0]            w_inflight;
    logic [7:0]            w_used;
    logic                  w_credit;
    logic                  w_pipe_empty;
    logic                  w_fifo_drained;
    logic                  w_unused_ctrl;

    assign w_unused_ctrl  = ^control_signal[31:2];
    assign w_start_rise   = control_signal[0] & ~r_start_d;
    assign w_abort_req    = control_signal[1];
    assign w_flush        = w_abort_req & ((r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN));
    assign w_out_valid    = (r_count != '0);
    assign w_pop          = w_out_valid & out_ready;
    assign w_push         = r_pipe_vld[RD_LATENCY-1];
    assign w_used         = 8'(r_count) + w_inflight;
    // Conservative credit: pops this cycle are not counted, so nothing can land in a full FIFO
    assign w_credit       = (w_used < 8'(FIFO_DEPTH));
    assign w_pipe_empty   = (w_inflight == 8'd0);
    assign w_fifo_drained = (r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop);

    // Count reads presented to the BRAMs or still in the latency pipe
    always_comb begin
        w_inflight = {7'd0, |r_bram_en};
        for (int j = 0; j < RD_LATENCY; j++) begin
            w_inflight = w_inflight + {7'd0, r_pipe_vld[j]};
        end
    end

    // Select the returning bank's slice of the read data bus
    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_pipe_bank[RD_LATENCY-1] == 2'(i)) begin
                w_push_data = bram_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control FSM: start detection, read issue, completion and abort
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_start_d   <= 1'b0;
            r_next_addr <= '0;
            r_next_bank <= 2'd0;
            r_remaining <= '0;
            r_bram_en   <= 4'd0;
            r_bram_addr <= '0;
            r_bram_bank <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_start_d <= control_signal[0];
            r_bram_en <= 4'd0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_rise && !w_abort_req) begin
                        r_done    <= 1'b0;
                        r_aborted <= 1'b0;
                        if (word_count == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // First read goes out straight from the sampled inputs
                            r_state     <= c_ST_ISSUE;
                            r_busy      <= 1'b1;
                            r_bram_en   <= 4'b0001;
                            r_bram_addr <= base_addr;
                            r_bram_bank <= 2'd0;
                            r_next_bank <= 2'd1;
                            r_next_addr <= base_addr;
                            r_remaining <= {word_count, 2'b00} - c_REM_W'(1);
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (w_abort_req) begin
                        r_state   <= c_ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_remaining == '0) begin
                        r_state <= c_ST_DRAIN;
                    end else if (w_credit) begin
                        r_bram_en   <= 4'b0001 << r_next_bank;
                        r_bram_addr <= r_next_addr;
                        r_bram_bank <= r_next_bank;
                        r_next_bank <= r_next_bank + 2'd1;
                        if (r_next_bank == 2'd3) begin
                            r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                        end
                        r_remaining <= r_remaining - c_REM_W'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (w_abort_req) begin
                        r_state   <= c_ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_pipe_empty && w_fifo_drained) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Latency pipe: follows each issued read until its data appears on the bus
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            for (int j = 0; j < RD_LATENCY; j++) begin
                r_pipe_vld[j]  <= 1'b0;
                r_pipe_bank[j] <= 2'd0;
            end
        end else begin
            r_pipe_vld[0]  <= |r_bram_en;
            r_pipe_bank[0] <= r_bram_bank;
            for (int j = 1; j < RD_LATENCY; j++) begin
                r_pipe_vld[j]  <= r_pipe_vld[j-1];
                r_pipe_bank[j] <= r_pipe_bank[j-1];
            end
        end
    end

    // Return FIFO: push from the pipe tail, pop on handshake, flushed on abort
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_pipe_bank[RD_LATENCY-1], w_push_data};
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bram_en       = r_bram_en;
    assign bram_addr     = r_bram_addr;
    assign out_valid     = w_out_valid;
    // Head entry is gated so the stream reads 0 while empty
    assign out_data      = w_out_valid ? r_mem[r_rd_ptr][DATA_WIDTH-1:0] : '0;
    assign out_bank      = w_out_valid ? r_mem[r_rd_ptr][DATA_WIDTH+1:DATA_WIDTH] : 2'd0;
    assign status_signal = {16'd0, 8'(r_count), 5'd0, r_aborted, r_done, r_busy};

endmodule
`default_nettype wire

// File: tb/tb_bram4_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram4_read_sequencer
// Description : Self-checking bench for bram4_read_sequencer with a 4-bank
//               BRAM model of two-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram4_read_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] control_signal;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [3:0]  bram_en;
    logic [9:0]  bram_addr;
    logic [31:0] bram_rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_bank;
    logic [31:0] status_signal;

    int n_checks = 0;
    int n_errors = 0;

    bram4_read_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .control_signal(control_signal),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_rd_data  (bram_rd_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bank      (out_bank),
        .status_signal (status_signal)
    );

    always #5 clk = ~clk;

    // BRAM model: bank i at address a holds {i, a[5:0]}; two-cycle read latency
    logic [3:0] en_d1 = 4'd0, en_d2 = 4'd0;
    logic [9:0] a_d1 = 10'd0, a_d2 = 10'd0;
    always @(posedge clk) begin
        en_d1 <= bram_en;
        a_d1  <= bram_addr;
        en_d2 <= en_d1;
        a_d2  <= a_d1;
    end
    always_comb begin
        bram_rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            bram_rd_data[i*8 +: 8] = en_d2[i] ? {2'(i), a_d2[5:0]} : 8'hEE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [10:0] wc;
        int          rdy_period;
        int          exp_words;
        logic [31:0] exp_status;
    } vec_t;

    // Run one transfer, checking issue order, latency, stream order and final status
    task automatic run_vec(input vec_t v);
        int          n_iss;
        int          n_out;
        int          first_k;
        int          fin_k;
        bit          finished;
        bit          prev_stall;
        logic [9:0]  ea;
        logic [1:0]  eb;
        n_iss = 0; n_out = 0; first_k = -1; prev_stall = 0; finished = 0;
        fin_k = (v.exp_words == 0) ? 0 : -1;
        @(posedge clk); #1;
        control_signal[0] = 1'b0;
        base_addr = v.base; word_count = v.wc; out_ready = 1'b0;
        @(posedge clk); #1;
        control_signal[0] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2000; k++) begin
            #1;
            out_ready = ((k % v.rdy_period) == 0);
            @(negedge clk);
            if (fin_k >= 0 && k == fin_k + 1) begin
                check("end_status", status_signal, v.exp_status);
                check("end_no_valid", {31'd0, out_valid}, 32'd0);
                finished = 1;
                break;
            end
            if (bram_en != 4'd0) begin
                ea = v.base + 10'(n_iss / 4);
                eb = 2'(n_iss % 4);
                if (n_iss == 0) check("first_issue_cycle", k, 1);
                check("issue_en_addr", {18'd0, bram_en, bram_addr}, {18'd0, 4'b0001 << eb, ea});
                n_iss++;
            end
            if (prev_stall) check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            if (out_valid && first_k < 0) begin
                first_k = k;
                check("first_valid_cycle", k, 4);
            end
            if (status_signal[15:8] > 8'd8) check("occupancy_le_8", status_signal[15:8], 8);
            if (out_valid) begin
                ea = v.base + 10'(n_out / 4);
                eb = 2'(n_out % 4);
                check("word", {22'd0, out_bank, out_data}, {22'd0, eb, eb, ea[5:0]});
                if (out_ready) begin
                    n_out++;
                    if (n_out == v.exp_words) fin_k = k;
                end
            end
            prev_stall = out_valid && !out_ready;
            @(posedge clk);
        end
        if (!finished) check("transfer_timeout", 32'd1, 32'd0);
        check("issue_total", n_iss, v.exp_words);
    endtask

    vec_t vecs[5];

    initial begin
        int cnt;
        vecs[0] = '{10'h010, 11'd3, 1, 12, 32'h0000_0002};
        vecs[1] = '{10'h3FE, 11'd3, 1, 12, 32'h0000_0002};
        vecs[2] = '{10'h100, 11'd8, 3, 32, 32'h0000_0002};
        vecs[3] = '{10'h3FF, 11'd2, 2,  8, 32'h0000_0002};
        vecs[4] = '{10'h000, 11'd0, 1,  0, 32'h0000_0002};

        rst = 1'b1; control_signal = 32'd0; base_addr = 10'd0; word_count = 11'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {13'd0, bram_en, bram_addr, out_valid, out_bank, out_data},
              32'd0);
        check("reset_status", status_signal, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // start held high after a zero-length transfer must not retrigger
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bram_en != 4'd0 || status_signal[0]) cnt++;
        end
        check("held_start_no_restart", cnt, 0);
        check("held_start_status", status_signal, 32'h0000_0002);

        // abort five cycles into a 16-word transfer
        @(posedge clk); #1;
        control_signal = 32'd0; base_addr = 10'h020; word_count = 11'd16; out_ready = 1'b1;
        @(posedge clk); #1;
        control_signal[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        control_signal[1] = 1'b1;
        @(negedge clk);
        check("pre_abort_issue", {18'd0, bram_en, bram_addr}, {18'd0, 4'b0001, 10'h021});
        check("pre_abort_busy", {31'd0, status_signal[0]}, 32'd1);
        @(posedge clk); #1;
        control_signal[1] = 1'b0;
        @(negedge clk);
        check("abort_en_valid", {27'd0, bram_en, out_valid}, 32'd0);
        check("abort_status", status_signal, 32'h0000_0004);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || bram_en != 4'd0) cnt++;
        end
        check("abort_no_late_data", cnt, 0);
        run_vec(vecs[0]);

        // abort and start in the same idle cycle: abort wins
        @(posedge clk); #1;
        control_signal = 32'd0;
        @(posedge clk); #1;
        control_signal = 32'd3;
        @(posedge clk); #1;
        control_signal = 32'd1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bram_en != 4'd0 || status_signal[0]) cnt++;
        end
        check("abort_beats_start", cnt, 0);

        // reset during drain
        @(posedge clk); #1;
        control_signal = 32'd0; base_addr = 10'h040; word_count = 11'd1; out_ready = 1'b0;
        @(posedge clk); #1;
        control_signal[0] = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("drain_status", status_signal, 32'h0000_0401);
        check("drain_head", {22'd0, out_valid, out_bank, out_data}, {22'd0, 1'b1, 2'd0, 8'h00});
        @(posedge clk); #1;
        rst = 1'b1; control_signal = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midop_reset_outputs", {13'd0, bram_en, bram_addr, out_valid, out_bank, out_data},
              32'd0);
        check("midop_reset_status", status_signal, 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midop_no_stale_valid", cnt, 0);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
